// File: rtl/ddram_pkg.sv
// Shared types and widths for the DDRAM_* Avalon-MM responder.
package ddram_pkg;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_DATA} ddr_state_t;

  localparam int DDR_DW  = 64;
  localparam int DDR_BEW = 8;
  localparam int DDR_AW  = 29;

  // A burst count of zero is a one-beat burst.
  function automatic logic [7:0] burst_len_m1(input logic [7:0] cnt);
    return (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
  endfunction

endpackage

// File: rtl/bram_be64.sv
// Single-port 64-bit RAM with per-byte write enables and a registered read.
// The read register only loads on i_re, so o_q holds the last word read.
module bram_be64
  import ddram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DDR_BEW-1:0]  i_we,
  input  logic                i_re,
  input  logic [DDR_DW-1:0]   i_wdata,
  output logic [DDR_DW-1:0]   o_q
);

  logic [DDR_DW-1:0] r_mem [2**ADDR_W];
  logic [DDR_DW-1:0] r_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DDR_BEW; i++) begin
      if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_re) r_q <= r_mem[i_addr];
  end

  assign o_q = r_q;

endmodule

// File: rtl/ddram_bram_responder.sv
// Avalon-MM burst responder for the DDRAM_* port, backed by on-chip 64-bit block RAM.
// Reads: first beat READ_LAT+1 cycles after acceptance, beats back to back; optional wait-state injection.
module ddram_bram_responder
  import ddram_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int READ_LAT   = 2,
  parameter int BUSY_EVERY = 0
) (
  input  logic                clk,
  input  logic                N_RESET,
  output logic                DDRAM_BUSY,
  input  logic [7:0]          DDRAM_BURSTCNT,
  input  logic [DDR_AW-1:0]   DDRAM_ADDR,
  input  logic                DDRAM_RD,
  output logic [DDR_DW-1:0]   DDRAM_DOUT,
  output logic                DDRAM_DOUT_READY,
  input  logic                DDRAM_WE,
  input  logic [DDR_DW-1:0]   DDRAM_DIN,
  input  logic [DDR_BEW-1:0]  DDRAM_BE
);

  localparam logic [3:0]  LAT_INIT   = 4'(READ_LAT - 1);
  localparam logic [15:0] STALL_LAST = (BUSY_EVERY > 0) ? 16'(BUSY_EVERY - 1) : 16'd0;

  ddr_state_t          r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt, w_ram_addr, w_req_idx;
  logic [7:0]          r_beats, w_beats_nxt, w_len_m1;
  logic [3:0]          r_lat, w_lat_nxt;
  logic [15:0]         r_stall_cnt;
  logic [DDR_BEW-1:0]  w_ram_we;
  logic                w_ram_re, w_inject, w_reading, w_busy;
  logic                w_unused;

  assign w_req_idx = DDRAM_ADDR[ADDR_W-1:0];
  assign w_len_m1  = burst_len_m1(DDRAM_BURSTCNT);
  assign w_unused  = ^DDRAM_ADDR[DDR_AW-1:ADDR_W];

  // Injected stalls are masked while reading so read beats are never delayed.
  assign w_inject  = (BUSY_EVERY > 0) && (r_stall_cnt == STALL_LAST);
  assign w_reading = (r_state == RD_WAIT) || (r_state == RD_DATA);
  assign w_busy    = w_reading || w_inject;

  assign DDRAM_BUSY       = w_busy;
  assign DDRAM_DOUT_READY = (r_state == RD_DATA);

  always_ff @(posedge clk or negedge N_RESET) begin
    if (!N_RESET) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_beats <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_beats <= w_beats_nxt;
      r_lat   <= w_lat_nxt;
    end
  end

  always_ff @(posedge clk or negedge N_RESET) begin
    if (!N_RESET)            r_stall_cnt <= '0;
    else if (BUSY_EVERY > 1) r_stall_cnt <= (r_stall_cnt == STALL_LAST) ? 16'd0 : r_stall_cnt + 16'd1;
  end

  // The RAM read is issued one cycle ahead of each DOUT_READY beat.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_beats_nxt = r_beats;
    w_lat_nxt   = r_lat;
    w_ram_addr  = r_addr;
    w_ram_we    = '0;
    w_ram_re    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_busy && DDRAM_WE) begin
          w_ram_addr = w_req_idx;
          w_ram_we   = DDRAM_BE;
          w_addr_nxt = w_req_idx + ADDR_W'(1);
          if (w_len_m1 != 8'd0) begin
            w_beats_nxt = w_len_m1 - 8'd1;
            w_state_nxt = WR_BURST;
          end
        end else if (!w_busy && DDRAM_RD) begin
          w_addr_nxt  = w_req_idx;
          w_beats_nxt = w_len_m1;
          w_lat_nxt   = LAT_INIT;
          w_state_nxt = RD_WAIT;
        end
      end
      WR_BURST: begin
        if (DDRAM_WE && !w_busy) begin
          w_ram_we   = DDRAM_BE;
          w_addr_nxt = r_addr + ADDR_W'(1);
          if (r_beats == 8'd0) w_state_nxt = IDLE;
          else                 w_beats_nxt = r_beats - 8'd1;
        end
      end
      RD_WAIT: begin
        if (r_lat == 4'd0) begin
          w_ram_re    = 1'b1;
          w_addr_nxt  = r_addr + ADDR_W'(1);
          w_state_nxt = RD_DATA;
        end else begin
          w_lat_nxt = r_lat - 4'd1;
        end
      end
      RD_DATA: begin
        if (r_beats == 8'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_ram_re    = 1'b1;
          w_addr_nxt  = r_addr + ADDR_W'(1);
          w_beats_nxt = r_beats - 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  bram_be64 #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .rst_n   (N_RESET),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_wdata (DDRAM_DIN),
    .o_q     (DDRAM_DOUT)
  );

endmodule

// File: tb/tb_ddram_bram_responder.sv
// Bench for ddram_bram_responder: instance 0 never stalls, instance 1 injects BUSY every 3 cycles.
module tb_ddram_bram_responder;

  localparam int RL = 2;

  int checks   = 0;
  int failures = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rd = '0, we = '0, busy, dvld;
  logic [28:0] addr [2];
  logic [7:0]  bcnt [2];
  logic [7:0]  be   [2];
  logic [63:0] din  [2];
  logic [63:0] dout [2];

  logic [63:0] model_mem [2][1024];
  logic [63:0] exp_q [$];
  logic [63:0] wr_data [16];
  logic [7:0]  wr_be   [16];
  int          stall_before [16];
  int          s_cyc;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_cyc <= 0;
    else        s_cyc <= s_cyc + 1;
  end

  ddram_bram_responder #(.ADDR_W(10), .READ_LAT(RL), .BUSY_EVERY(0)) dut (
    .clk(clk), .N_RESET(rst_n), .DDRAM_BUSY(busy[0]), .DDRAM_BURSTCNT(bcnt[0]),
    .DDRAM_ADDR(addr[0]), .DDRAM_RD(rd[0]), .DDRAM_DOUT(dout[0]), .DDRAM_DOUT_READY(dvld[0]),
    .DDRAM_WE(we[0]), .DDRAM_DIN(din[0]), .DDRAM_BE(be[0]));

  ddram_bram_responder #(.ADDR_W(10), .READ_LAT(RL), .BUSY_EVERY(3)) dut_s (
    .clk(clk), .N_RESET(rst_n), .DDRAM_BUSY(busy[1]), .DDRAM_BURSTCNT(bcnt[1]),
    .DDRAM_ADDR(addr[1]), .DDRAM_RD(rd[1]), .DDRAM_DOUT(dout[1]), .DDRAM_DOUT_READY(dvld[1]),
    .DDRAM_WE(we[1]), .DDRAM_DIN(din[1]), .DDRAM_BE(be[1]));

  function automatic logic exp_inject(input int sel);
    return (sel == 1) && (s_cyc % 3 == 2);
  endfunction

  task automatic write_burst(input string name, input int sel, input logic [28:0] a,
                             input logic [7:0] cnt, input int n);
    logic [9:0] idx;
    int tries;
    bit ok;
    idx = a[9:0];
    for (int b = 0; b < n; b++) begin
      for (int s = 0; s < stall_before[b]; s++) begin
        @(negedge clk);
        we[sel] = 1'b0; din[sel] = 64'hDEAD_BEEF_DEAD_BEEF; be[sel] = 8'hFF;
      end
      ok = 0; tries = 0;
      while (!ok && tries < 20) begin
        @(negedge clk);
        checks++;
        if (busy[sel] !== exp_inject(sel)) begin
          failures++;
          $display("FAIL %s wr_busy beat %0d: got %b want %b", name, b, busy[sel], exp_inject(sel));
        end
        we[sel] = 1'b1; din[sel] = wr_data[b]; be[sel] = wr_be[b];
        addr[sel] = (b == 0) ? a : ~a;
        bcnt[sel] = (b == 0) ? cnt : 8'hEE;
        if (busy[sel] === 1'b0) ok = 1;
        else tries++;
      end
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL %s wr_accept beat %0d: got busy for %0d cycles want accept", name, b, tries);
      end
      for (int i = 0; i < 8; i++)
        if (wr_be[b][i]) model_mem[sel][idx][8*i +: 8] = wr_data[b][8*i +: 8];
      idx++;
    end
    @(negedge clk);
    we[sel] = 1'b0;
  endtask

  task automatic read_burst(input string name, input int sel, input logic [28:0] a,
                            input logic [7:0] cnt);
    int n, tries;
    logic [9:0] idx;
    logic [63:0] e, last;
    logic ev, eb;
    n = (cnt == 8'd0) ? 1 : int'(cnt);
    last = '0;
    tries = 0;
    @(negedge clk);
    while (busy[sel] !== 1'b0 && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    checks++;
    if (tries >= 20) begin
      failures++;
      $display("FAIL %s rd_idle: got busy stuck want idle", name);
    end
    rd[sel] = 1'b1; addr[sel] = a; bcnt[sel] = cnt;
    idx = a[9:0];
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_mem[sel][idx]);
      idx++;
    end
    for (int k = 1; k <= n + RL + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin rd[sel] = 1'b0; addr[sel] = ~a; end
      ev = (k >= RL + 1) && (k < RL + 1 + n);
      eb = (k <= RL + n) ? 1'b1 : exp_inject(sel);
      checks++;
      if (dvld[sel] !== ev) begin
        failures++;
        $display("FAIL %s rd_valid cyc T+%0d: got %b want %b", name, k, dvld[sel], ev);
      end
      checks++;
      if (busy[sel] !== eb) begin
        failures++;
        $display("FAIL %s rd_busy cyc T+%0d: got %b want %b", name, k, busy[sel], eb);
      end
      if (ev) begin
        e = exp_q.pop_front();
        last = e;
        checks++;
        if (dout[sel] !== e) begin
          failures++;
          $display("FAIL %s rd_data cyc T+%0d: got %h want %h", name, k, dout[sel], e);
        end
      end
    end
    checks++;
    if (dout[sel] !== last) begin
      failures++;
      $display("FAIL %s dout_hold: got %h want %h", name, dout[sel], last);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (busy[s] !== 1'b0 || dvld[s] !== 1'b0 || dout[s] !== 64'd0) begin
        failures++;
        $display("FAIL reset dut%0d: got busy=%b rdy=%b dout=%h want 0 0 0", s, busy[s], dvld[s], dout[s]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 4; i++) begin
      wr_data[i] = {16{4'(i + 1)}};
      wr_be[i] = 8'hFF;
    end
    write_burst("wr_burst", 0, 29'h10, 8'd4, 4);
    read_burst("rd_burst", 0, 29'h10, 8'd4);
  endtask

  task automatic test_byte_enable();
    wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF; wr_be[0] = 8'hFF;
    write_burst("be_full", 0, 29'h20, 8'd1, 1);
    wr_data[0] = 64'h0; wr_be[0] = 8'h0F;
    write_burst("be_part", 0, 29'h20, 8'd1, 1);
    read_burst("be_read", 0, 29'h20, 8'd1);
  endtask

  task automatic test_zero_len_wrap();
    wr_data[0] = 64'h0123_4567_89AB_CDEF; wr_be[0] = 8'hFF;
    write_burst("wrap_pre", 0, 29'h0, 8'd1, 1);
    wr_data[0] = 64'hA5A5_A5A5_5A5A_5A5A;
    write_burst("zero_len", 0, 29'h1000_03FF, 8'd0, 1);
    read_burst("wrap_read", 0, 29'h3FF, 8'd2);
  endtask

  task automatic test_write_stall();
    wr_data[0] = 64'h5555_5555_5555_5555; wr_be[0] = 8'hFF;
    write_burst("stall_pre", 0, 29'h44, 8'd1, 1);
    for (int i = 0; i < 4; i++) begin
      wr_data[i] = 64'hC0C0_C0C0_0000_0000 + 64'(i);
      wr_be[i] = 8'hFF;
    end
    stall_before[2] = 3;
    write_burst("wr_stall", 0, 29'h40, 8'd4, 4);
    stall_before[2] = 0;
    read_burst("stall_read", 0, 29'h40, 8'd5);
  endtask

  task automatic test_stall_inject();
    for (int i = 0; i < 8; i++) begin
      wr_data[i] = 64'h8000_0000_0000_0000 | 64'(i * 3 + 1);
      wr_be[i] = 8'hFF;
    end
    write_burst("inj_write", 1, 29'h80, 8'd8, 8);
    read_burst("inj_read", 1, 29'h80, 8'd8);
  endtask

  task automatic test_reset_mid_read();
    int tries;
    for (int i = 0; i < 8; i++) begin
      wr_data[i] = {8{8'(8'h10 + i)}};
      wr_be[i] = 8'hFF;
    end
    write_burst("rst_write", 0, 29'h100, 8'd8, 8);
    tries = 0;
    @(negedge clk);
    while (busy[0] !== 1'b0 && tries < 20) begin @(negedge clk); tries++; end
    rd[0] = 1'b1; addr[0] = 29'h100; bcnt[0] = 8'd8;
    for (int k = 1; k <= RL + 2; k++) begin
      @(negedge clk);
      if (k == 1) rd[0] = 1'b0;
      if (k > RL) begin
        checks++;
        if (dvld[0] !== 1'b1 || dout[0] !== model_mem[0][10'h100 + 10'(k - RL - 1)]) begin
          failures++;
          $display("FAIL rst_pre_beat %0d: got rdy=%b data=%h want 1 %h", k - RL, dvld[0], dout[0],
                   model_mem[0][10'h100 + 10'(k - RL - 1)]);
        end
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dvld[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: got rdy=%b busy=%b want 0 0", dvld[0], busy[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (dvld[0] !== 1'b0 || busy[0] !== 1'b0) begin
        failures++;
        $display("FAIL rst_quiet cyc %0d: got rdy=%b busy=%b want 0 0", k, dvld[0], busy[0]);
      end
    end
    read_burst("rst_reread", 0, 29'h100, 8'd8);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      addr[s] = '0; bcnt[s] = '0; be[s] = '0; din[s] = '0;
    end
    for (int i = 0; i < 16; i++) stall_before[i] = 0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_zero_len_wrap();
    test_write_stall();
    test_stall_inject();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
